// File: rtl/snow64_vector_alu_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | snow64_vector_alu_sequencer_pkg                                    |
// | Shared types, widths and the per-element integer ALU function.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package snow64_vector_alu_sequencer_pkg;

   localparam int WIDTH__VECTOR_DEFAULT = 256;
   localparam int WIDTH__CHUNK_DEFAULT  = 64;
   localparam int NUM_CHUNKS_DEFAULT    = WIDTH__VECTOR_DEFAULT / WIDTH__CHUNK_DEFAULT;

   // Op codes 10..15 are undefined and produce zero.
   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_SLT = 4'd2,
      OP_AND = 4'd3,
      OP_ORR = 4'd4,
      OP_XOR = 4'd5,
      OP_SHL = 4'd6,
      OP_SHR = 4'd7,
      OP_INV = 4'd8,
      OP_NOT = 4'd9
   } alu_op_t;

   typedef enum logic [1:0] {
      INT_SIZE_8  = 2'd0,
      INT_SIZE_16 = 2'd1,
      INT_SIZE_32 = 2'd2,
      INT_SIZE_64 = 2'd3
   } int_type_size_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } seq_state_t;

   // Control fields latched with each accepted request.
   typedef struct packed {
      logic [3:0] oper;
      logic       unsgn_or_sgn;
      logic [1:0] int_type_size;
   } port_in_vec_alu_seq_t;

   typedef struct packed {
      logic valid;
      logic ready;
   } port_out_vec_alu_seq_t;

   // One element of width w (8/16/32/64) held in the low bits of a and b.
   // Upper bits of the inputs are ignored; the result is zero above bit w-1.
   function automatic logic [63:0] alu_elem(
      input logic [3:0]  oper,
      input logic        sgn,
      input logic [6:0]  w,
      input logic [63:0] a,
      input logic [63:0] b
   );
      logic [63:0] mask, top, ax, bx, as, bs, r;
      logic        big, neg_a;
      mask  = (w == 7'd64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      top   = mask ^ (mask >> 1);
      ax    = a & mask;
      bx    = b & mask;
      neg_a = |(ax & top);
      as    = ax | (neg_a ? ~mask : 64'd0);
      bs    = bx | ((|(bx & top)) ? ~mask : 64'd0);
      big   = (bx >= {57'd0, w});
      r     = 64'd0;
      case (oper)
         OP_ADD: r = (ax + bx) & mask;
         OP_SUB: r = (ax - bx) & mask;
         OP_SLT: r = {63'd0, sgn ? ($signed(as) < $signed(bs)) : (ax < bx)};
         OP_AND: r = ax & bx;
         OP_ORR: r = ax | bx;
         OP_XOR: r = ax ^ bx;
         OP_SHL: r = big ? 64'd0 : ((ax << bx[5:0]) & mask);
         OP_SHR: begin
            if (sgn)
               r = big ? (neg_a ? mask : 64'd0) : (64'($signed(as) >>> bx[5:0]) & mask);
            else
               r = big ? 64'd0 : (ax >> bx[5:0]);
         end
         OP_INV: r = ~ax & mask;
         OP_NOT: r = {63'd0, (ax == 64'd0)};
         default: r = 64'd0;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/snow64_vector_alu_sequencer_alu_chunk.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | snow64_alu_chunk                                                   |
// | Combinational 64-bit chunk ALU: 8/16/32/64-bit lanes, size mux.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module snow64_alu_chunk
   import snow64_vector_alu_sequencer_pkg::*;
(
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic [3:0]  oper,
   input  logic        unsgn_or_sgn,
   input  logic [1:0]  int_type_size,
   output logic [63:0] result
);

   logic [63:0] res_8, res_16, res_32, res_64;

   // Each lane sees only its own element bits, so nothing bleeds across lanes.
   always_comb begin
      res_8  = 64'd0;
      res_16 = 64'd0;
      res_32 = 64'd0;
      for (int i = 0; i < 8; i++)
         res_8 = res_8 | (alu_elem(oper, unsgn_or_sgn, 7'd8, a >> (8 * i), b >> (8 * i)) << (8 * i));
      for (int i = 0; i < 4; i++)
         res_16 = res_16 | (alu_elem(oper, unsgn_or_sgn, 7'd16, a >> (16 * i), b >> (16 * i)) << (16 * i));
      for (int i = 0; i < 2; i++)
         res_32 = res_32 | (alu_elem(oper, unsgn_or_sgn, 7'd32, a >> (32 * i), b >> (32 * i)) << (32 * i));
      res_64 = alu_elem(oper, unsgn_or_sgn, 7'd64, a, b);
   end

   // Select the lane set matching the element size.
   always_comb begin
      result = 64'd0;
      case (int_type_size)
         INT_SIZE_8:  result = res_8;
         INT_SIZE_16: result = res_16;
         INT_SIZE_32: result = res_32;
         default:     result = res_64;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/snow64_vector_alu_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | snow64_vector_alu_sequencer                                        |
// | Streams a full operand vector through one chunk ALU, one 64-bit    |
// | chunk per cycle, and holds the result under valid/ready.           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module snow64_vector_alu_sequencer
   import snow64_vector_alu_sequencer_pkg::*;
#(
   parameter int WIDTH__VECTOR = WIDTH__VECTOR_DEFAULT,
   parameter int WIDTH__CHUNK  = WIDTH__CHUNK_DEFAULT
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     out_ready,
   input  logic [WIDTH__VECTOR-1:0] in_a,
   input  logic [WIDTH__VECTOR-1:0] in_b,
   input  logic [3:0]               in_oper,
   input  logic                     in_unsgn_or_sgn,
   input  logic [1:0]               in_int_type_size,
   output logic                     out_valid,
   input  logic                     in_result_ready,
   output logic [WIDTH__VECTOR-1:0] out_data
);

   localparam int              NUM_CHUNKS = WIDTH__VECTOR / WIDTH__CHUNK;
   localparam int              K_WIDTH    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam logic [K_WIDTH-1:0] K_LAST  = K_WIDTH'(NUM_CHUNKS - 1);

   seq_state_t              state;
   logic [K_WIDTH-1:0]      k;
   logic [WIDTH__VECTOR-1:0] a_q, b_q;
   port_in_vec_alu_seq_t    ctrl_q, ctrl_in;
   logic [WIDTH__CHUNK-1:0] chunk_a, chunk_b, chunk_res;
   logic                    accept;

   // Ready depends only on registered state and the consumer, never on in_valid.
   assign out_ready = (state == ST_IDLE) | ((state == ST_DONE) & in_result_ready);
   assign accept    = in_valid & out_ready;

   assign ctrl_in = '{oper: in_oper, unsgn_or_sgn: in_unsgn_or_sgn, int_type_size: in_int_type_size};
   assign chunk_a = a_q[WIDTH__CHUNK * k +: WIDTH__CHUNK];
   assign chunk_b = b_q[WIDTH__CHUNK * k +: WIDTH__CHUNK];

   snow64_alu_chunk u_alu_chunk (
      .a             (chunk_a),
      .b             (chunk_b),
      .oper          (ctrl_q.oper),
      .unsgn_or_sgn  (ctrl_q.unsgn_or_sgn),
      .int_type_size (ctrl_q.int_type_size),
      .result        (chunk_res)
   );

   // Sequencer FSM: latch on accept, write one chunk per RUN cycle, hold in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         k         <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         a_q       <= '0;
         b_q       <= '0;
         ctrl_q    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  a_q    <= in_a;
                  b_q    <= in_b;
                  ctrl_q <= ctrl_in;
                  k      <= '0;
                  state  <= ST_RUN;
               end
            end
            ST_RUN: begin
               out_data[WIDTH__CHUNK * k +: WIDTH__CHUNK] <= chunk_res;
               if (k == K_LAST) begin
                  k         <= '0;
                  out_valid <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  k <= k + 1'b1;
               end
            end
            ST_DONE: begin
               if (in_result_ready) begin
                  out_valid <= 1'b0;
                  if (accept) begin
                     a_q    <= in_a;
                     b_q    <= in_b;
                     ctrl_q <= ctrl_in;
                     k      <= '0;
                     state  <= ST_RUN;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
